// File: rtl/program_counter.sv
// Fetch-stage program counter: holds the fetch address and picks the next one from
// PC+4, a PC-relative branch target, or an absolute register value (BR).
module program_counter #(
  parameter int unsigned condAddrSize = 19,
  parameter int unsigned brAddrSize   = 26
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [condAddrSize-1:0] condAddr19,
  input  logic [brAddrSize-1:0]   brAddr26,
  input  logic                    uncondBr,
  input  logic                    brTaken,
  input  logic                    branchReg,
  input  logic [63:0]             Rd,
  output logic [63:0]             nextPC,
  output logic [63:0]             pc_plus4
);

  logic [63:0] pc_q;
  logic [63:0] pc_d;
  logic [63:0] cond_off;
  logic [63:0] br_off;
  logic [63:0] word_off;
  logic [63:0] byte_off;
  logic [63:0] br_target;
  logic [63:0] seq_or_branch;

  // Offset path: sign extend both encodings, pick one, scale words to bytes.
  always_comb begin
    cond_off = {{(64 - condAddrSize){condAddr19[condAddrSize-1]}}, condAddr19};
    br_off   = {{(64 - brAddrSize){brAddr26[brAddrSize-1]}}, brAddr26};
    word_off = uncondBr ? br_off : cond_off;
    byte_off = {word_off[61:0], 2'b00};
  end

  // Both adders wrap modulo 2^64; carry-out is intentionally dropped.
  always_comb begin
    br_target = pc_q + byte_off;
    pc_plus4  = pc_q + 64'd4;
  end

  always_comb begin
    seq_or_branch = brTaken ? br_target : pc_plus4;
    pc_d          = branchReg ? Rd : seq_or_branch;
  end

  // One flop per address bit, each with its own synchronous reset.
  for (genvar i = 0; i < 64; i++) begin : g_pc_bit
    always_ff @(posedge clock) begin
      if (reset) begin
        pc_q[i] <= 1'b0;
      end else begin
        pc_q[i] <= pc_d[i];
      end
    end
  end

  assign nextPC = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed checks of the program counter: reset, sequential run, BR load, branches,
// negative offsets, address wrap and reset priority.
module tb_program_counter;

  logic        clock = 1'b0;
  logic        reset;
  logic [18:0] condAddr19;
  logic [25:0] brAddr26;
  logic        uncondBr;
  logic        brTaken;
  logic        branchReg;
  logic [63:0] Rd;
  logic [63:0] nextPC;
  logic [63:0] pc_plus4;

  int checks = 0;
  int errors = 0;

  program_counter dut (
    .clock      (clock),
    .reset      (reset),
    .condAddr19 (condAddr19),
    .brAddr26   (brAddr26),
    .uncondBr   (uncondBr),
    .brTaken    (brTaken),
    .branchReg  (branchReg),
    .Rd         (Rd),
    .nextPC     (nextPC),
    .pc_plus4   (pc_plus4)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_pc(input logic [63:0] val);
    branchReg = 1'b1;
    Rd        = val;
    tick();
    branchReg = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    condAddr19 = '0;
    brAddr26   = '0;
    uncondBr   = 1'b0;
    brTaken    = 1'b0;
    branchReg  = 1'b0;
    Rd         = '0;

    tick();
    check("reset_pc", nextPC, 64'd0);
    check("reset_plus4", pc_plus4, 64'd4);
    tick();
    check("reset_held_pc", nextPC, 64'd0);

    reset = 1'b0;
    tick();
    check("seq_1", nextPC, 64'd4);
    tick();
    check("seq_2", nextPC, 64'd8);
    tick();
    check("seq_3", nextPC, 64'd12);

    // branchReg wins over an asserted brTaken
    branchReg = 1'b1;
    Rd        = 64'd69;
    brTaken   = 1'b1;
    uncondBr  = 1'b1;
    brAddr26  = 26'd2;
    tick();
    check("br_reg_pc", nextPC, 64'd69);
    check("br_reg_plus4", pc_plus4, 64'd73);
    branchReg = 1'b0;
    brTaken   = 1'b0;

    load_pc(64'd15);
    check("load_15", nextPC, 64'd15);
    condAddr19 = 19'd30;
    uncondBr   = 1'b0;
    brTaken    = 1'b1;
    tick();
    check("cond_branch", nextPC, 64'd135);
    brTaken = 1'b0;

    load_pc(64'd0);
    check("load_0", nextPC, 64'd0);
    brAddr26 = 26'd2;
    uncondBr = 1'b1;
    brTaken  = 1'b1;
    tick();
    check("uncond_branch", nextPC, 64'd8);
    brTaken = 1'b0;
    load_pc(64'd0);
    tick();
    check("uncond_not_taken", nextPC, 64'd4);

    load_pc(64'd200);
    condAddr19 = 19'h7FFFF;
    uncondBr   = 1'b0;
    brTaken    = 1'b1;
    tick();
    check("cond_neg1", nextPC, 64'd196);
    brTaken = 1'b0;

    load_pc(64'd200);
    brAddr26 = 26'h3FFFFFB;
    uncondBr = 1'b1;
    brTaken  = 1'b1;
    tick();
    check("uncond_neg5", nextPC, 64'd180);
    brTaken = 1'b0;

    // Large negative conditional offset from a small PC wraps below zero
    load_pc(64'd16);
    condAddr19 = 19'h40000;
    uncondBr   = 1'b0;
    brTaken    = 1'b1;
    tick();
    check("cond_min_wrap", nextPC, 64'hFFFF_FFFF_FFF0_0010);
    brTaken = 1'b0;

    load_pc(64'hFFFF_FFFF_FFFF_FFFC);
    check("plus4_wrap_comb", pc_plus4, 64'd0);
    tick();
    check("seq_wrap", nextPC, 64'd0);

    load_pc(64'd40);
    reset     = 1'b1;
    brTaken   = 1'b1;
    branchReg = 1'b1;
    Rd        = 64'd69;
    tick();
    check("reset_mid_branch", nextPC, 64'd0);
    reset     = 1'b0;
    brTaken   = 1'b0;
    branchReg = 1'b0;
    tick();
    check("resume_1", nextPC, 64'd4);
    tick();
    check("resume_2", nextPC, 64'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
